// File: rtl/board_ctrl.sv
// ---------------------------------------------------------------------------
// board_ctrl -- tic-tac-toe game-state controller
//
// Accepts move requests (square 1..9, row-major, 1 = top-left), validates
// them against the current board, records X/O ownership, alternates turns and
// detects win / draw. Per-square display flags for the overlay stages are
// shadow-registered on the rising edge of vertical blank so they never change
// in the middle of a frame.
//
// Ports
//   pclk        in   pixel clock
//   rst         in   synchronous active-high reset
//   new_game    in   one-cycle request: clear board and restart
//   move_valid  in   move request strobe, held until accepted
//   move_sq     in   [3:0] requested square 1..9
//   move_ready  out  move can be accepted this cycle
//   move_ack    out  one-cycle pulse: move accepted and written
//   move_nack   out  one-cycle pulse: move rejected
//   turn        out  player to move (0 = X, 1 = O)
//   game_state  out  [1:0] 0 playing, 1 X won, 2 O won, 3 draw
//   vblnk_in    in   vertical blank from the timing chain
//   sq_x        out  [8:0] shadowed X ownership, bit k-1 = square k
//   sq_o        out  [8:0] shadowed O ownership
//   win_line    out  [8:0] shadowed squares on completed winning lines
// ---------------------------------------------------------------------------
module board_ctrl #(
    parameter bit START_PLAYER = 1'b0
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_sq,
    output logic       move_ready,
    output logic       move_ack,
    output logic       move_nack,
    output logic       turn,
    output logic [1:0] game_state,
    input  logic       vblnk_in,
    output logic [8:0] sq_x,
    output logic [8:0] sq_o,
    output logic [8:0] win_line
);

    typedef enum logic [1:0] {
        S_PLAY,
        S_VALIDATE,
        S_CHECK,
        S_OVER
    } state_t;

    // Rows, columns, then the two diagonals.
    localparam logic [8:0] LINE_MASK [8] = '{
        9'h007, 9'h038, 9'h1C0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };

    state_t     state_q, state_d;
    logic [8:0] board_x_q, board_x_d;
    logic [8:0] board_o_q, board_o_d;
    logic [8:0] win_q, win_d;
    logic [3:0] count_q, count_d;
    logic [3:0] sq_q, sq_d;
    logic       turn_q, turn_d;
    logic [1:0] gs_q, gs_d;
    logic       ack_q, ack_d;
    logic       nack_q, nack_d;

    logic       vblnk_d_q;
    logic [8:0] sq_x_q, sq_o_q, win_line_q;

    logic [8:0] sq_onehot;
    logic       move_bad;
    logic [8:0] cur_board;
    logic [7:0] line_hit;
    logic [8:0] hit_mask;

    // Latched square decoded to a board bit; out-of-range squares give zero.
    always_comb begin
        sq_onehot = '0;
        for (int k = 0; k < 9; k++) begin
            if (sq_q == 4'(k + 1)) begin
                sq_onehot[k] = 1'b1;
            end
        end
    end

    assign move_bad  = (sq_onehot == 9'd0) || ((sq_onehot & (board_x_q | board_o_q)) != 9'd0);
    // Only the player who just moved can have completed a line.
    assign cur_board = turn_q ? board_o_q : board_x_q;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_line
            assign line_hit[gi] = ((cur_board & LINE_MASK[gi]) == LINE_MASK[gi]);
        end
    endgenerate

    // Every completed line is highlighted, so double wins show both lines.
    always_comb begin
        hit_mask = '0;
        for (int l = 0; l < 8; l++) begin
            if (line_hit[l]) begin
                hit_mask = hit_mask | LINE_MASK[l];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        board_x_d = board_x_q;
        board_o_d = board_o_q;
        win_d     = win_q;
        count_d   = count_q;
        sq_d      = sq_q;
        turn_d    = turn_q;
        gs_d      = gs_q;
        ack_d     = 1'b0;
        nack_d    = 1'b0;

        case (state_q)
            S_PLAY: begin
                if (move_valid) begin
                    sq_d    = move_sq;
                    state_d = S_VALIDATE;
                end
            end
            S_VALIDATE: begin
                if (move_bad) begin
                    nack_d  = 1'b1;
                    state_d = S_PLAY;
                end else begin
                    if (turn_q) begin
                        board_o_d = board_o_q | sq_onehot;
                    end else begin
                        board_x_d = board_x_q | sq_onehot;
                    end
                    count_d = count_q + 4'd1;
                    ack_d   = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (line_hit != 8'd0) begin
                    gs_d    = turn_q ? 2'd2 : 2'd1;
                    win_d   = hit_mask;
                    state_d = S_OVER;
                end else if (count_q == 4'd9) begin
                    gs_d    = 2'd3;
                    win_d   = '0;
                    state_d = S_OVER;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = S_PLAY;
                end
            end
            default: begin
                // S_OVER: requests are ignored until new_game.
            end
        endcase

        // Restart overrides everything, including a move in flight, which is
        // dropped silently. Display shadows are left to the next vblank.
        if (new_game) begin
            state_d   = S_PLAY;
            board_x_d = '0;
            board_o_d = '0;
            win_d     = '0;
            count_d   = '0;
            turn_d    = START_PLAYER;
            gs_d      = 2'd0;
            ack_d     = 1'b0;
            nack_d    = 1'b0;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q   <= S_PLAY;
            board_x_q <= '0;
            board_o_q <= '0;
            win_q     <= '0;
            count_q   <= '0;
            sq_q      <= '0;
            turn_q    <= START_PLAYER;
            gs_q      <= 2'd0;
            ack_q     <= 1'b0;
            nack_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            board_x_q <= board_x_d;
            board_o_q <= board_o_d;
            win_q     <= win_d;
            count_q   <= count_d;
            sq_q      <= sq_d;
            turn_q    <= turn_d;
            gs_q      <= gs_d;
            ack_q     <= ack_d;
            nack_q    <= nack_d;
        end
    end

    // Shadows load the board as it stands in the vblank rising cycle; a write
    // landing in that same cycle waits for the next frame.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vblnk_d_q  <= 1'b0;
            sq_x_q     <= '0;
            sq_o_q     <= '0;
            win_line_q <= '0;
        end else begin
            vblnk_d_q <= vblnk_in;
            if (vblnk_in && !vblnk_d_q) begin
                sq_x_q     <= board_x_q;
                sq_o_q     <= board_o_q;
                win_line_q <= win_q;
            end
        end
    end

    assign move_ready = (state_q == S_PLAY);
    assign move_ack   = ack_q;
    assign move_nack  = nack_q;
    assign turn       = turn_q;
    assign game_state = gs_q;
    assign sq_x       = sq_x_q;
    assign sq_o       = sq_o_q;
    assign win_line   = win_line_q;

endmodule
